// File: rtl/usb_joypad_ctl.sv
// USB joypad report capture and NES serial controller port.
//
// Captures HID reports strobed byte-by-byte from a USB host core, decodes the
// directional and button bytes into the NES button layout, commits complete
// reports, clears buttons on timeout or connection error, and serves the
// buttons through an NES $4016-style shift register.
//
// Ports:
//   usbclk      12 MHz clock, rising edge
//   usbrst_n    asynchronous active-low reset
//   ukprdy      report frame active
//   ukpstb      byte strobe (rising edge qualifies ukpdat)
//   ukpdat      report byte
//   conerr      connection error / host watchdog
//   joy_strobe  NES latch level
//   joy_rd      one-cycle pulse per NES read
//   joy_dout    serial button bit
//   btn_nes     committed buttons {right,left,down,up,start,select,B,A}
//   rpt_valid   one-cycle pulse per committed report
//   stale       no report committed within TIMEOUT_CYC
//   short_cnt   saturating count of discarded short reports
module usb_joypad_ctl #(
  parameter int unsigned TIMEOUT_CYC = 600000,
  parameter int unsigned MIN_BYTES   = 7
) (
  input  logic       usbclk,
  input  logic       usbrst_n,
  input  logic       ukprdy,
  input  logic       ukpstb,
  input  logic [7:0] ukpdat,
  input  logic       conerr,
  input  logic       joy_strobe,
  input  logic       joy_rd,
  output logic       joy_dout,
  output logic [7:0] btn_nes,
  output logic       rpt_valid,
  output logic       stale,
  output logic [7:0] short_cnt
);

  localparam int unsigned TmoW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {StIdle, StRecv, StCommit} state_e;

  state_e          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      stg_q, stg_d;
  logic [7:0]      btn_q, btn_d;
  logic [7:0]      sh_q, sh_d;
  logic            rpt_q, rpt_d;
  logic            stale_q, stale_d;
  logic [7:0]      short_q, short_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            rdy_q, stb_q;

  logic       rdy_rise, rdy_fall, stb_rise;
  logic       commit, short_inc;
  logic [2:0] idx_inc, byte_cnt;

  // Low nibble of the report bytes carries nothing the NES needs.
  logic unused_dat;
  assign unused_dat = ^ukpdat[3:0];

  assign rdy_rise = ukprdy & ~rdy_q;
  assign rdy_fall = ~ukprdy & rdy_q;
  assign stb_rise = ukpstb & ~stb_q;

  assign idx_inc  = (idx_q == 3'd7) ? 3'd7 : idx_q + 3'd1;
  // A byte strobed in the same cycle as the frame end still counts.
  assign byte_cnt = stb_rise ? idx_inc : idx_q;

  // Capture FSM
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    stg_d     = stg_q;
    commit    = 1'b0;
    short_inc = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rdy_rise) begin
          state_d = StRecv;
          idx_d   = 3'd0;
          stg_d   = 8'h00;
        end
      end
      StRecv: begin
        if (stb_rise) begin
          idx_d = idx_inc;
          case (idx_q)
            3'd3: begin
              stg_d[4] = (ukpdat[7:6] == 2'b00);
              stg_d[5] = (ukpdat[7:6] == 2'b11);
            end
            3'd4: begin
              stg_d[6] = (ukpdat[7:6] == 2'b00);
              stg_d[7] = (ukpdat[7:6] == 2'b11);
            end
            3'd5: begin
              stg_d[0] = ukpdat[5];
              stg_d[1] = ukpdat[6];
            end
            3'd6: begin
              stg_d[2] = ukpdat[4];
              stg_d[3] = ukpdat[5];
            end
            default: ;
          endcase
        end
        if (rdy_fall) begin
          if (32'(byte_cnt) >= MIN_BYTES) begin
            state_d = StCommit;
          end else begin
            state_d   = StIdle;
            short_inc = 1'b1;
            stg_d     = 8'h00;
          end
        end
      end
      StCommit: begin
        commit  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (conerr) begin
      state_d   = StIdle;
      commit    = 1'b0;
      short_inc = 1'b0;
    end
  end

  // Committed buttons, timeout and status
  always_comb begin
    btn_d   = btn_q;
    stale_d = stale_q;
    tmo_d   = tmo_q;
    rpt_d   = commit;
    short_d = short_q;
    if (short_inc && short_q != 8'hFF) short_d = short_q + 8'd1;
    if (conerr) begin
      btn_d   = 8'h00;
      stale_d = 1'b1;
      tmo_d   = '0;
    end else if (commit) begin
      btn_d   = stg_q;
      stale_d = 1'b0;
      tmo_d   = '0;
    end else begin
      if (tmo_q != TmoMax) tmo_d = tmo_q + 1'b1;
      // Expire on the cycle the counter lands on its limit; it then holds.
      if (tmo_d == TmoMax) begin
        btn_d   = 8'h00;
        stale_d = 1'b1;
      end
    end
  end

  // NES shift register; a load during COMMIT sees the old btn_q.
  always_comb begin
    sh_d = sh_q;
    if (joy_strobe) begin
      sh_d = btn_q;
    end else if (joy_rd) begin
      sh_d = {1'b1, sh_q[7:1]};
    end
  end

  always_ff @(posedge usbclk or negedge usbrst_n) begin
    if (!usbrst_n) begin
      state_q <= StIdle;
      idx_q   <= 3'd0;
      stg_q   <= 8'h00;
      btn_q   <= 8'h00;
      sh_q    <= 8'hFF;
      rpt_q   <= 1'b0;
      stale_q <= 1'b1;
      short_q <= 8'h00;
      tmo_q   <= '0;
      rdy_q   <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      stg_q   <= stg_d;
      btn_q   <= btn_d;
      sh_q    <= sh_d;
      rpt_q   <= rpt_d;
      stale_q <= stale_d;
      short_q <= short_d;
      tmo_q   <= tmo_d;
      rdy_q   <= ukprdy;
      stb_q   <= ukpstb;
    end
  end

  assign joy_dout  = sh_q[0];
  assign btn_nes   = btn_q;
  assign rpt_valid = rpt_q;
  assign stale     = stale_q;
  assign short_cnt = short_q;

endmodule

// File: tb/tb_usb_joypad_ctl.sv
// Randomized self-checking bench for usb_joypad_ctl against a report-level model.
module tb_usb_joypad_ctl;

  localparam int unsigned Tmo  = 100;
  localparam int unsigned MinB = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ukprdy = 1'b0, ukpstb = 1'b0, conerr = 1'b0;
  logic [7:0] ukpdat = 8'h00;
  logic       joy_strobe = 1'b0, joy_rd = 1'b0;
  logic       joy_dout, rpt_valid, stale;
  logic [7:0] btn_nes, short_cnt;

  usb_joypad_ctl #(
    .TIMEOUT_CYC (Tmo),
    .MIN_BYTES   (MinB)
  ) dut (
    .usbclk     (clk),
    .usbrst_n   (rst_n),
    .ukprdy     (ukprdy),
    .ukpstb     (ukpstb),
    .ukpdat     (ukpdat),
    .conerr     (conerr),
    .joy_strobe (joy_strobe),
    .joy_rd     (joy_rd),
    .joy_dout   (joy_dout),
    .btn_nes    (btn_nes),
    .rpt_valid  (rpt_valid),
    .stale      (stale),
    .short_cnt  (short_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int pulses = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rpt_valid) pulses <= pulses + 1;
  end

  int n_chk = 0;
  int n_err = 0;

  // Model state: last committed buttons, when they were committed, and
  // whether a reset/conerr has forced the port into its cleared state.
  logic [7:0] exp_btn = 8'h00;
  int         exp_short = 0;
  int         last_cyc = 0;
  bit         forced = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ref_btn(input logic [7:0] b [8], input int n);
    logic up, down, left, right, a, bb, sel, st;
    logic [7:0] v;
    {up, down, left, right, a, bb, sel, st} = '0;
    if (n > 3) begin
      v = b[3];
      up   = (v >> 6) == 0;
      down = (v >> 6) == 3;
    end
    if (n > 4) begin
      v = b[4];
      left  = (v >> 6) == 0;
      right = (v >> 6) == 3;
    end
    if (n > 5) begin
      v = b[5];
      a  = v[5];
      bb = v[6];
    end
    if (n > 6) begin
      v = b[6];
      sel = v[4];
      st  = v[5];
    end
    return {right, left, down, up, st, sel, bb, a};
  endfunction

  task automatic check_state(input string tag);
    int el;
    el = cyc - last_cyc;
    check({tag, "_short"}, short_cnt, exp_short);
    if (forced || el >= int'(Tmo) - 1) begin
      check({tag, "_btn"}, btn_nes, 8'h00);
      check({tag, "_stale"}, stale, 1'b1);
    end else begin
      check({tag, "_btn"}, btn_nes, exp_btn);
      check({tag, "_stale"}, stale, 1'b0);
    end
  endtask

  task automatic do_report(input string tag, input int n, input logic [7:0] b [8],
                           input bit merge);
    int  base;
    int  t;
    bit  seen;
    base = pulses;
    ukprdy = 1'b1;
    tick();
    tick();
    for (int i = 0; i < n; i++) begin
      ukpdat = b[i];
      if (merge && i == n - 1) begin
        ukpstb = 1'b1;
        ukprdy = 1'b0;
        tick();
        ukpstb = 1'b0;
        tick();
      end else begin
        ukpstb = 1'b1;
        tick();
        ukpstb = 1'b0;
        tick();
        repeat ($urandom_range(0, 2)) tick();
      end
    end
    if (!merge) begin
      ukprdy = 1'b0;
      tick();
    end
    seen = 1'b0;
    t = cyc;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (rpt_valid && !seen) begin
        seen = 1'b1;
        t = cyc;
      end
    end
    if (n >= int'(MinB)) begin
      exp_btn  = ref_btn(b, n);
      forced   = 1'b0;
      last_cyc = t;
      check({tag, "_pulse"}, pulses - base, 1);
    end else begin
      if (exp_short < 255) exp_short++;
      check({tag, "_pulse"}, pulses - base, 0);
    end
    check_state(tag);
  endtask

  task automatic joy_read(input string tag, input logic [7:0] v, input int nrd);
    joy_strobe = 1'b1;
    joy_rd = 1'b1;
    tick();
    joy_rd = 1'b0;
    tick();
    joy_strobe = 1'b0;
    tick();
    for (int i = 0; i < nrd; i++) begin
      check(tag, joy_dout, (i < 8) ? v[i] : 1'b1);
      joy_rd = 1'b1;
      tick();
      joy_rd = 1'b0;
      tick();
    end
  endtask

  logic [7:0] b [8];

  initial begin
    tick();
    tick();
    check("rst_btn", btn_nes, 8'h00);
    check("rst_stale", stale, 1'b1);
    check("rst_short", short_cnt, 8'h00);
    check("rst_rpt", rpt_valid, 1'b0);
    check("rst_dout", joy_dout, 1'b1);
    rst_n = 1'b1;
    tick();

    // Full 8-byte report
    b = '{8'h11, 8'h22, 8'h33, 8'h00, 8'hFF, 8'h60, 8'h30, 8'hAA};
    do_report("r8", 8, b, 1'b0);
    check("r8_val", btn_nes, 8'h9F);

    // Short report leaves buttons alone
    b = '{8'h01, 8'h02, 8'h03, 8'hC0, 8'h00, 8'h00, 8'h00, 8'h00};
    do_report("r5", 5, b, 1'b0);
    check("r5_val", btn_nes, 8'h9F);
    check("r5_cnt", short_cnt, 8'd1);

    // Last byte strobed with the frame end brings a 7-byte report up to length
    b = '{8'h00, 8'h00, 8'h00, 8'h40, 8'h40, 8'h20, 8'h10, 8'h00};
    do_report("merge7", 7, b, 1'b1);
    check("merge7_val", btn_nes, 8'h05);
    joy_read("joy05", 8'h05, 10);

    // Timeout
    while (cyc - last_cyc < int'(Tmo) - 2) tick();
    check_state("tmo_pre");
    while (cyc - last_cyc < int'(Tmo) - 1) tick();
    check("tmo_btn", btn_nes, 8'h00);
    check("tmo_stale", stale, 1'b1);
    b = '{8'h00, 8'h00, 8'h00, 8'hC0, 8'h00, 8'h20, 8'h20, 8'h00};
    do_report("tmo_rec", 7, b, 1'b0);

    // Connection error mid-report
    ukprdy = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      ukpdat = 8'hFF;
      ukpstb = 1'b1;
      tick();
      ukpstb = 1'b0;
      tick();
    end
    conerr = 1'b1;
    tick();
    forced = 1'b1;
    check_state("conerr");
    conerr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ukpstb = 1'b1;
      tick();
      ukpstb = 1'b0;
      tick();
    end
    ukprdy = 1'b0;
    repeat (4) tick();
    check_state("conerr_end");
    b = '{8'h11, 8'h22, 8'h33, 8'h00, 8'hFF, 8'h60, 8'h30, 8'hAA};
    do_report("conerr_rec", 8, b, 1'b0);
    check("conerr_rec_val", btn_nes, 8'h9F);

    // Randomized reports
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
      do_report($sformatf("rnd%0d", r), $urandom_range(3, 8), b, 1'($urandom_range(0, 1)));
      if (!forced && (cyc - last_cyc) < 20 && $urandom_range(0, 2) == 0)
        joy_read($sformatf("rnd%0d_joy", r), exp_btn, 9);
    end

    // Reset in the middle of a report
    ukprdy = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      ukpdat = 8'h00;
      ukpstb = 1'b1;
      tick();
      ukpstb = 1'b0;
      tick();
    end
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_btn", btn_nes, 8'h00);
    check("arst_stale", stale, 1'b1);
    check("arst_short", short_cnt, 8'h00);
    check("arst_rpt", rpt_valid, 1'b0);
    check("arst_dout", joy_dout, 1'b1);
    ukprdy = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    exp_short = 0;
    forced = 1'b1;
    check_state("post_rst");
    b = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hC0, 8'h40, 8'h20, 8'h00};
    do_report("post_rst_rep", 7, b, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/usb_joypad_ctl.md
USB_JOYPAD_CTL -- requirements
Module: usb_joypad_ctl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 600000, meaning the number of usbclk cycles without a committed report before buttons are cleared (50 ms at 12 MHz).
REQ-002 The block SHALL have parameter MIN_BYTES, default 7, meaning the minimum strobed byte count for a report to be accepted.
REQ-003 usbclk  input  1  12 MHz clock; all logic SHALL be clocked on its rising edge.
REQ-004 usbrst_n  input  1  asynchronous active-low reset.
REQ-005 ukprdy  input  1  report frame active, from the USB host core.
REQ-006 ukpstb  input  1  byte strobe; its rising edge qualifies ukpdat.
REQ-007 ukpdat  input  8  report byte.
REQ-008 conerr  input  1  connection error / host watchdog flag.
REQ-009 joy_strobe  input  1  NES $4016 bit0 latch level, synchronous to usbclk.
REQ-010 joy_rd  input  1  one-cycle pulse, one per NES $4016 read.
REQ-011 joy_dout  output  1  serial button bit to the NES.
REQ-012 btn_nes  output  8  committed buttons {right,left,down,up,start,select,B,A}, active-high.
REQ-013 rpt_valid  output  1  one-cycle pulse per committed report.
REQ-014 stale  output  1  high while no report has been committed within TIMEOUT_CYC.
REQ-015 short_cnt  output  8  saturating count of discarded short reports.

Function
REQ-016 Edge detection SHALL use one registered copy each of ukprdy and ukpstb; a rise or fall is seen one cycle after the input changes.
REQ-017 The capture FSM SHALL have states IDLE, RECV and COMMIT.
REQ-018 IDLE SHALL go to RECV on a ukprdy rise and clear the 3-bit byte index idx.
REQ-019 In RECV, each ukpstb rise SHALL decode ukpdat at the current idx into the staging register, then increment idx, saturating at 7.
REQ-020 Decode at idx 3: [7:6]=00 sets up=1, down=0; 11 sets down=1, up=0; otherwise both are 0.
REQ-021 Decode at idx 4: [7:6]=00 sets left=1, right=0; 11 sets right=1, left=0; otherwise both are 0.
REQ-022 Decode at idx 5: A=bit5 and B=bit6.
REQ-023 Decode at idx 6: select=bit4 and start=bit5.
REQ-024 Bytes at other indices SHALL be ignored.
REQ-025 In RECV, a ukprdy fall SHALL go to COMMIT if the received byte count is at least MIN_BYTES, else to IDLE with short_cnt+1 (saturating at 255) and the staging register discarded.
REQ-026 If a ukpstb rise and a ukprdy fall occur in the same cycle, the byte SHALL be decoded and counted before the length check.
REQ-027 COMMIT SHALL last one cycle: btn_nes<=staging, rpt_valid=1, timeout counter<=0, stale<=0, then go to IDLE.
REQ-028 The staging register SHALL be cleared on every IDLE->RECV transition.
REQ-029 conerr=1 in any state SHALL force IDLE, clear btn_nes, set stale=1, and hold the timeout counter at 0; short_cnt SHALL NOT increment.
REQ-030 The timeout counter SHALL increment every cycle outside COMMIT.
REQ-031 When the timeout counter reaches TIMEOUT_CYC-1, btn_nes SHALL clear, stale SHALL set, and the counter SHALL hold (no wrap).
REQ-032 The NES port SHALL use an 8-bit shift register sh, with joy_dout=sh[0].
REQ-033 While joy_strobe=1, sh<=btn_nes every cycle, and joy_rd SHALL be ignored.
REQ-034 While joy_strobe=0, each joy_rd SHALL do sh<={1'b1,sh[7:1]}; after 8 reads joy_dout SHALL read 1 indefinitely.
REQ-035 A load in the same cycle as COMMIT SHALL take the pre-commit btn_nes; the new value SHALL load on the next strobed cycle.
REQ-036 Report latency SHALL be 2 cycles from the ukprdy fall at the pins to btn_nes updated (1 cycle edge detect + COMMIT).

Reset
REQ-037 On usbrst_n=0, the block SHALL asynchronously set: state=IDLE, idx=0, staging=0, btn_nes=0, sh=8'hFF, rpt_valid=0, stale=1, short_cnt=0, timeout counter=0, edge registers=0.
REQ-038 Reset asserted mid-RECV SHALL discard the partial report without counting it as short.

Verification
REQ-039 Scenario: an 8-byte report with byte3=00h, byte4=FFh, byte5=60h, byte6=30h -> btn_nes=8'b1001_1111, rpt_valid is one pulse, and stale=0.
REQ-040 Scenario: a 5-byte report after a valid report -> btn_nes is unchanged, short_cnt=1, and rpt_valid stays 0.
REQ-041 Scenario: btn_nes=8'h05, strobe high then low, 10 joy_rd pulses -> joy_dout sequence before each read is 1,0,1,0,0,0,0,0,1,1.
REQ-042 Scenario: no report for TIMEOUT_CYC cycles (parameter overridden to 100) -> on cycle 99 btn_nes=0 and stale=1; a later valid report clears stale.
REQ-043 Scenario: conerr pulsed mid-RECV -> returns to IDLE, btn_nes=0, and the following valid report commits normally.
REQ-044 Scenario: usbrst_n asserted mid-RECV -> all outputs at reset values immediately, without waiting for a clock edge.
